// File: rtl/gene_feeder.sv
// Query/reference source for the PE array: buffers query A and reference B from the host,
// then streams A one base per cycle against a static B bus and holds busy while the array drains.
module gene_feeder #(
    parameter int N_PE      = 64,
    parameter int MAX_A     = 64,
    parameter int DRAIN_CYC = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_valid,
    input  logic                i_wr_sel,
    input  logic [1:0]          i_wr_base,
    output logic                o_wr_ready,
    input  logic                i_clr_B,
    input  logic                i_go,
    output logic                o_start,
    output logic [1:0]          o_A,
    output logic [2*N_PE-1:0]   o_B,
    output logic                o_busy,
    output logic                o_done
);

    localparam int AW   = (MAX_A > 1) ? $clog2(MAX_A) : 1;
    localparam int BW   = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int PAW  = $clog2(MAX_A + 1);
    localparam int PBW  = $clog2(N_PE + 1);
    localparam int CMAX = (MAX_A > DRAIN_CYC) ? MAX_A : DRAIN_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]     state;
    logic [PAW-1:0] ptr_a;
    logic [PBW-1:0] ptr_b;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  ptr_a_ext;
    logic [1:0]     a_mem [MAX_A];
    logic [1:0]     b_mem [N_PE];

    logic idle;
    logic a_full;
    logic b_full;
    logic wr_acc;
    logic wr_a;
    logic wr_b;
    logic go_ok;

    assign idle       = (state == S_IDLE);
    assign a_full     = (ptr_a == PAW'(MAX_A));
    assign b_full     = (ptr_b == PBW'(N_PE));
    assign o_wr_ready = idle && (i_wr_sel ? !b_full : !a_full);
    assign wr_acc     = i_wr_valid && o_wr_ready;
    assign wr_a       = wr_acc && !i_wr_sel;
    // A clear in the same cycle overrides a reference write, which is then not counted as accepted.
    assign wr_b       = wr_acc && i_wr_sel && !i_clr_B;
    assign go_ok      = idle && i_go && (ptr_a != '0) && !(wr_a || wr_b);
    assign ptr_a_ext  = CW'(ptr_a);
    assign o_busy     = (state == S_STREAM) || (state == S_DRAIN);

    for (genvar k = 0; k < N_PE; k++) begin : g_bbus
        assign o_B[2*k +: 2] = b_mem[k];
    end

    // Query storage carries no reset; only the write pointer defines valid contents.
    always_ff @(posedge i_clk) begin
        if (wr_a) begin
            a_mem[ptr_a[AW-1:0]] <= i_wr_base;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            ptr_a   <= '0;
            ptr_b   <= '0;
            cnt     <= '0;
            o_start <= 1'b0;
            o_A     <= '0;
            o_done  <= 1'b0;
            for (int k = 0; k < N_PE; k++) begin
                b_mem[k] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_clr_B) begin
                        ptr_b <= '0;
                        for (int k = 0; k < N_PE; k++) begin
                            b_mem[k] <= '0;
                        end
                    end else if (wr_b) begin
                        b_mem[ptr_b[BW-1:0]] <= i_wr_base;
                        ptr_b                <= ptr_b + 1'b1;
                    end
                    if (wr_a) begin
                        ptr_a <= ptr_a + 1'b1;
                    end
                    // First base is registered on the go edge; cnt then tracks the next index to present.
                    if (go_ok) begin
                        state   <= S_STREAM;
                        o_start <= 1'b1;
                        o_A     <= a_mem[0];
                        cnt     <= CW'(1);
                    end
                end
                S_STREAM: begin
                    if (cnt == ptr_a_ext) begin
                        state   <= S_DRAIN;
                        o_start <= 1'b0;
                        o_A     <= '0;
                        cnt     <= '0;
                    end else begin
                        o_A <= a_mem[cnt[AW-1:0]];
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(DRAIN_CYC - 1)) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ptr_a <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
